// File: rtl/ps2_rx_deserializer.sv
// ps2_rx_deserializer: synchronizes, filters and deframes PS/2 device-to-host frames.
module ps2_rx_deserializer #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_error,
  output logic [1:0] err_code,
  output logic       busy
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3;
  logic clk_s1, clk_s2, dat_s1, dat_s2, clk_f, clk_f_d, fe, tmo, par;
  logic [7:0] flt_cnt, shift;
  logic [2:0] bit_cnt;
  logic [TW-1:0] to_cnt;
  logic [1:0] state, state_n;
  assign fe = clk_f_d & ~clk_f;
  // an edge in the same cycle as the timeout keeps the frame alive
  assign tmo = !fe && state != IDLE && to_cnt == TW'(TIMEOUT_CYCLES - 1);
  always_comb
    state_n = fe ? (state == IDLE   ? (dat_s2 ? IDLE : DATA) :
                    state == DATA   ? (bit_cnt == 3'd7 ? PARITY : DATA) :
                    state == PARITY ? STOP : IDLE)
                 : tmo ? IDLE : state;
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      {clk_s1, clk_s2, dat_s1, dat_s2, clk_f, clk_f_d} <= 6'b111111;
      flt_cnt <= '0;
      state <= IDLE;
      bit_cnt <= '0;
      shift <= '0;
      par <= 1'b0;
      to_cnt <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
      err_code <= '0;
      busy <= 1'b0;
    end else begin
      {clk_s2, clk_s1} <= {clk_s1, ps2_clk_in};
      {dat_s2, dat_s1} <= {dat_s1, ps2_dat_in};
      flt_cnt <= (clk_s2 != clk_f && flt_cnt != 8'(FILTER_LEN - 1)) ? flt_cnt + 8'd1 : 8'd0;
      if (clk_s2 != clk_f && flt_cnt == 8'(FILTER_LEN - 1)) clk_f <= clk_s2;
      clk_f_d <= clk_f;
      state <= state_n;
      busy <= state_n != IDLE;
      to_cnt <= (fe || state == IDLE) ? '0 : to_cnt + 1'b1;
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
      if (fe && state == IDLE) bit_cnt <= '0;
      if (fe && state == DATA) begin
        shift[bit_cnt] <= dat_s2;
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (fe && state == PARITY) par <= dat_s2;
      if (fe && state == STOP) begin
        if (dat_s2 && (^shift ^ par)) begin
          rx_data <= shift;
          rx_valid <= 1'b1;
        end else begin
          rx_error <= 1'b1;
          err_code <= dat_s2 ? 2'd1 : 2'd2;
        end
      end else if (tmo) begin
        rx_error <= 1'b1;
        err_code <= 2'd3;
      end
    end
  end
endmodule

// File: doc/ps2_rx_deserializer.md
Name: ps2_rx_deserializer

Overview:
- Upstream receive stage of the keyboard path. Takes raw PS2_CLK/PS2_DAT pin levels, synchronizes and filters them, and deframes 11-bit PS/2 device-to-host frames.
- Each frame is start, 8 data bits LSB first, odd parity, stop.
- Delivers each good byte to the scancode/display logic as an 8-bit value with a one-cycle valid strobe. Bad frames are reported through error strobes.
- Receive-only. Tri-state pin handling stays at top level.

Parameters:
- FILTER_LEN, 8, number of consecutive equal synchronized samples required before the filtered PS/2 clock changes level (range 2..255).
- TIMEOUT_CYCLES, 10000, CLOCK_50 cycles without a filtered falling edge before an in-progress frame is aborted (200 us at 50 MHz).

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- reset  input  1  synchronous, active-high reset.
- ps2_clk_in  input  1  raw PS2_CLK pin level (asynchronous).
- ps2_dat_in  input  1  raw PS2_DAT pin level (asynchronous).
- rx_data  output  8  last correctly received byte.
- rx_valid  output  1  one-cycle pulse; rx_data is new in that same cycle.
- rx_error  output  1  one-cycle pulse on an aborted or bad frame.
- err_code  output  2  cause of the last error: 0 none, 1 parity, 2 framing (stop bit 0), 3 timeout; held until the next error or reset.
- busy  output  1  high while state is not IDLE.

Behaviour:
- Reset values: rx_data=0x00, rx_valid=0, rx_error=0, err_code=0, busy=0, state=IDLE. Synchronizers and the filtered clock reset to 1; filter counter resets to 0.
- Reset asserted mid-frame discards the partial frame with no error pulse. All state is synchronous to CLOCK_50.
- Synchronization: ps2_clk_in and ps2_dat_in each pass through 2 flip-flops.
- Clock filter: when the synchronized clock differs from the filtered value, count up. After FILTER_LEN consecutive differing samples, the filtered value flips. Any matching sample clears the count.
- Falling-edge strobe fe is one cycle, issued on a filtered 1->0 transition. The synchronized data is sampled in the fe cycle. Filter delay is far smaller than the half-bit period, so no data delay matching is needed.
- FSM states and transitions, all advancing only on fe:
  - IDLE: if sampled data=0, go to DATA and set bit_cnt=0. If data=1, stay in IDLE silently.
  - DATA: shift the sampled bit into shift[bit_cnt] (LSB first). After bit_cnt=7, go to PARITY.
  - PARITY: latch the parity bit, go to STOP.
  - STOP: always return to IDLE. If stop=1 and (XOR of data bits XOR parity)=1, load rx_data and pulse rx_valid the next cycle. Otherwise pulse rx_error the next cycle and set err_code: stop=0 gives 2 (framing, checked first); bad parity gives 1.
- Output latency: rx_valid or rx_error rises exactly 1 cycle after the stop-bit fe.
- rx_data changes only on a good frame; errors leave it unchanged.
- Timeout:
  - The idle counter clears on every fe and in IDLE.
  - In DATA, PARITY or STOP, if the counter reaches TIMEOUT_CYCLES-1 without an fe: go to IDLE, pulse rx_error, set err_code=3.
  - If fe and the timeout occur in the same cycle, fe wins.
- rx_valid and rx_error are never high together. Back-to-back frames need no idle gap beyond the normal stop-to-start bit time.
- busy equals (state != IDLE), registered.

Test Plan:
- Good byte: frame 0x1C (bits 0,00111000,parity 0,stop 1) at a 60 us bit period -> exactly one rx_valid, rx_data=0x1C, 1 cycle after the stop fe; err_code stays 0.
- Back-to-back bytes: frames 0xF0 (parity 1) then 0x1C -> two rx_valid pulses, rx_data 0xF0 then 0x1C, no rx_error.
- Parity error: 0x1C sent with parity 1 -> one rx_error, err_code=1, rx_data keeps its prior value, no rx_valid. Stop bit 0 on an otherwise good 0x1C -> rx_error, err_code=2.
- Timeout (TIMEOUT_CYCLES=500): send start plus 3 data bits, then hold the clock high for 600 cycles -> rx_error with err_code=3 at cycle 500 after the last fe, busy=0. A following good 0xF0 frame is received correctly.
- Glitch rejection (FILTER_LEN=8): 3-cycle low pulse on ps2_clk_in in IDLE with dat=0 -> no fe, busy stays 0. A 20-cycle low pulse -> fe, busy=1.
- Reset mid-frame: assert reset after 5 data bits -> next cycle busy=0, rx_data=0x00, no rx_error. A complete 0x1C frame afterwards -> rx_valid, rx_data=0x1C.
